// File: rtl/ai_compressor_2_if.sv
// Handshake/data bundle between a feature-word producer and the compressor.
// The master drives the unpacked words; the slave returns packed words.
interface ai_compressor_2_if;
  logic        init;
  logic        compress;
  logic [63:0] data_in;
  logic        data_in_rdy;
  logic [63:0] data_out;
  logic        data_out_rdy;

  modport master (
    output init, compress, data_in, data_in_rdy,
    input  data_out, data_out_rdy
  );

  modport slave (
    input  init, compress, data_in, data_in_rdy,
    output data_out, data_out_rdy
  );
endinterface

// File: rtl/ai_compressor_2.sv
// Feature-word compressor: packs one act/last half-pair per accepted word into
// the 7-bit-per-field link format, alternating halves via the sel toggle.
module ai_compressor_2 #(
  parameter int unsigned SMOOTH_TH = 8
) (
  input  logic               clk,
  input  logic               rst,
  ai_compressor_2_if.slave   bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    PACK = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] b_data_in_q, b_data_in_d;
  logic        b_data_in_rdy_q, b_data_in_rdy_d;
  logic        sel_q, sel_d;
  logic        wsel_q, wsel_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  la_q, la_d;
  logic [7:0]  lb_q, lb_d;
  logic [63:0] packed_q, packed_d;
  logic [63:0] data_out_q, data_out_d;
  logic        data_out_rdy_q, data_out_rdy_d;

  logic        capture_s;
  logic        emit_s;
  logic [63:0] b_data_out_s;

  // Unsigned magnitude |a-b| compared against the threshold, no wrap.
  function automatic logic smooth(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] diff;
    if (x >= y) begin
      diff = x - y;
    end else begin
      diff = y - x;
    end
    return (32'(diff) <= 32'(SMOOTH_TH));
  endfunction

  // Masking bit 0 is the LSB truncation into 7-bit fields.
  function automatic logic [63:0] pack_word(
    input logic       s,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] la,
    input logic [7:0] lb
  );
    logic [63:0] w;
    w = 64'd0;
    if (s) begin
      w[55:48] = la & 8'hFE;
      w[47:40] = lb & 8'hFE;
    end else begin
      w[39:32] = la & 8'hFE;
      w[31:24] = lb & 8'hFE;
    end
    w[15:8] = (b & 8'hFE) | {7'd0, smooth(a, b)};
    w[7:0]  = a & 8'hFE;
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= LOAD;
      b_data_in_q     <= 64'd0;
      b_data_in_rdy_q <= 1'b0;
      sel_q           <= 1'b0;
      wsel_q          <= 1'b0;
      a_q             <= 8'd0;
      b_q             <= 8'd0;
      la_q            <= 8'd0;
      lb_q            <= 8'd0;
      packed_q        <= 64'd0;
      data_out_q      <= 64'd0;
      data_out_rdy_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      b_data_in_q     <= b_data_in_d;
      b_data_in_rdy_q <= b_data_in_rdy_d;
      sel_q           <= sel_d;
      wsel_q          <= wsel_d;
      a_q             <= a_d;
      b_q             <= b_d;
      la_q            <= la_d;
      lb_q            <= lb_d;
      packed_q        <= packed_d;
      data_out_q      <= data_out_d;
      data_out_rdy_q  <= data_out_rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (b_data_in_rdy_q && bus.compress) begin
          state_d = PACK;
        end else begin
          state_d = LOAD;
        end
      end
      PACK:    state_d = EMIT;
      EMIT:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    capture_s = 1'b0;
    emit_s    = 1'b0;
    case (state_q)
      LOAD:    capture_s = b_data_in_rdy_q && bus.compress;
      PACK:    emit_s    = 1'b0;
      EMIT:    emit_s    = 1'b1;
      default: emit_s    = 1'b0;
    endcase
  end

  always_comb begin
    b_data_in_d     = bus.data_in;
    b_data_in_rdy_d = bus.data_in_rdy;

    // init overrides the EMIT toggle; the word in flight keeps wsel_q.
    if (bus.init) begin
      sel_d = 1'b0;
    end else if (emit_s) begin
      sel_d = ~sel_q;
    end else begin
      sel_d = sel_q;
    end

    wsel_d = wsel_q;
    a_d    = a_q;
    b_d    = b_q;
    la_d   = la_q;
    lb_d   = lb_q;
    if (capture_s) begin
      wsel_d = sel_q;
      if (sel_q) begin
        a_d  = b_data_in_q[63:56];
        b_d  = b_data_in_q[55:48];
        la_d = b_data_in_q[31:24];
        lb_d = b_data_in_q[23:16];
      end else begin
        a_d  = b_data_in_q[47:40];
        b_d  = b_data_in_q[39:32];
        la_d = b_data_in_q[15:8];
        lb_d = b_data_in_q[7:0];
      end
    end else begin
      wsel_d = wsel_q;
    end

    if (state_q == PACK) begin
      packed_d = pack_word(wsel_q, a_q, b_q, la_q, lb_q);
    end else begin
      packed_d = packed_q;
    end

    if (emit_s) begin
      b_data_out_s = packed_q;
    end else begin
      b_data_out_s = 64'd0;
    end

    data_out_d     = b_data_out_s;
    data_out_rdy_d = emit_s;
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_out_rdy = data_out_rdy_q;

endmodule

// File: tb/tb_ai_compressor_2.sv
// Scoreboard bench for ai_compressor_2: expected words are queued when a
// strobe is driven and popped when data_out_rdy appears.
module tb_ai_compressor_2;

  logic clk;
  logic rst;
  ai_compressor_2_if bus ();

  ai_compressor_2 #(.SMOOTH_TH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] w;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   out_cnt = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic tb_sel = 1'b0;

  localparam logic [63:0] W1 = 64'h10203034AABBCCDD;
  localparam logic [63:0] W3 = 64'h0102030405060708;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic s, input logic [63:0] d);
    logic [7:0]  a, b, l1, l2, diff;
    logic [63:0] w;
    if (s) begin
      a = d[63:56]; b = d[55:48]; l1 = d[31:24]; l2 = d[23:16];
    end else begin
      a = d[47:40]; b = d[39:32]; l1 = d[15:8];  l2 = d[7:0];
    end
    diff = (a > b) ? a - b : b - a;
    w = 64'd0;
    if (s) begin
      w[55:48] = {l1[7:1], 1'b0};
      w[47:40] = {l2[7:1], 1'b0};
    end else begin
      w[39:32] = {l1[7:1], 1'b0};
      w[31:24] = {l2[7:1], 1'b0};
    end
    w[15:8] = {b[7:1], (diff <= 8'd8)};
    w[7:0]  = {a[7:1], 1'b0};
    return w;
  endfunction

  // Output monitor: pops the scoreboard on each strobe, checks zero otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      total_cnt++;
      if (bus.data_out_rdy === 1'b1) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_out: got data_out=%h with no word expected (cycle %0d)", bus.data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.data_out !== e.w || cyc != e.c) begin
            $display("FAIL out_word: got %h at cycle %0d, expected %h at cycle %0d", bus.data_out, cyc, e.w, e.c);
          end else begin
            pass_cnt++;
          end
        end
      end else begin
        if (bus.data_out !== 64'd0 || bus.data_out_rdy !== 1'b0) begin
          $display("FAIL idle_out: got data_out=%h rdy=%b, expected 0/0", bus.data_out, bus.data_out_rdy);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [63:0] w, input bit has_exp, input logic [63:0] exp_w);
    exp_t x;
    bus.data_in     = w;
    bus.data_in_rdy = 1'b1;
    if (has_exp) begin
      x.w = exp_w;
      x.c = cyc + 4;
      exp_q.push_back(x);
      tb_sel = ~tb_sel;
    end
    @(negedge clk);
    bus.data_in_rdy = 1'b0;
    bus.data_in     = 64'd0;
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    tb_sel   = 1'b0;
    @(negedge clk);
    bus.init = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d words still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus.data_out !== 64'd0) begin
      $display("FAIL reset_data_out: got %h, expected 0", bus.data_out);
    end else begin
      pass_cnt++;
    end
    total_cnt++;
    if (bus.data_out_rdy !== 1'b0) begin
      $display("FAIL reset_rdy: got %b, expected 0", bus.data_out_rdy);
    end else begin
      pass_cnt++;
    end
    rst    = 1'b0;
    tb_sel = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    pulse_init();
    send(W1, 1'b1, 64'h000000CCDC003530);
    gap(5);
    send(W1, 1'b1, 64'h00AABA0000002010);
    gap(5);
    send(W3, 1'b1, 64'h0000000608000502);
    drain("basic");
    gap(3);
  endtask

  task automatic test_boundary();
    pulse_init();
    send(64'h0000000800000000, 1'b1, 64'h0000000000000900);
    gap(5);
    pulse_init();
    send(64'h0000000900000000, 1'b1, 64'h0000000000000800);
    gap(5);
    send(64'h5047000000000000, 1'b1, 64'h0000000000004650);
    drain("boundary");
    gap(3);
  endtask

  task automatic test_back_to_back();
    int c0;
    pulse_init();
    c0 = out_cnt;
    send(W1, 1'b1, 64'h000000CCDC003530);
    send(W3, 1'b0, 64'd0);
    drain("b2b");
    gap(6);
    total_cnt++;
    if (out_cnt - c0 != 1) begin
      $display("FAIL b2b_count: got %0d outputs, expected 1", out_cnt - c0);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_compress_off();
    int c0;
    c0 = out_cnt;
    bus.compress = 1'b0;
    send(W3, 1'b0, 64'd0);
    gap(8);
    total_cnt++;
    if (out_cnt - c0 != 0) begin
      $display("FAIL compress_off_count: got %0d outputs, expected 0", out_cnt - c0);
    end else begin
      pass_cnt++;
    end
    bus.compress = 1'b1;
    send(W3, 1'b1, model(tb_sel, W3));
    drain("compress_on");
    gap(3);
  endtask

  task automatic test_init_emit();
    pulse_init();
    send(W3, 1'b1, model(tb_sel, W3));
    gap(2);
    pulse_init();
    gap(4);
    send(W1, 1'b1, model(tb_sel, W1));
    drain("init_emit");
    gap(3);
  endtask

  task automatic test_rst_pack();
    int c0;
    c0 = out_cnt;
    send(W3, 1'b0, 64'd0);
    gap(1);
    rst    = 1'b1;
    tb_sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    gap(8);
    total_cnt++;
    if (out_cnt - c0 != 0) begin
      $display("FAIL rst_pack_count: got %0d outputs, expected 0", out_cnt - c0);
    end else begin
      pass_cnt++;
    end
    send(W1, 1'b1, 64'h000000CCDC003530);
    drain("rst_pack");
    gap(3);
  endtask

  initial begin
    rst             = 1'b1;
    bus.init        = 1'b0;
    bus.compress    = 1'b1;
    bus.data_in     = 64'd0;
    bus.data_in_rdy = 1'b0;
    gap(3);
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_compress_off();
    test_init_emit();
    test_rst_pack();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
